// File: rtl/i2c_target_rx_ctrl.sv
// i2c_target_rx_ctrl: write-only I2C target receiver; syncs SCL/SDA, detects START/STOP, matches address, ACKs, strobes data bytes.
// Ports: clock, reset_n (async, active-low); scl_in/sda_in raw pad inputs; sda_oe open-drain pull-low enable;
// rx_data/rx_valid received byte and one-cycle strobe; addr_hit from address ACK until STOP/START; busy between START and STOP.
// Optional: define I2C_GLITCH_FILTER_EN to add a 3-sample stability filter after the synchronizers.
module i2c_target_rx_ctrl #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop, match;
  logic [3:0] cnt, cnt_n, cnt_inc;
  logic [7:0] shift, shift_n, rx_data_n;
  logic sda_oe_n, rx_valid_n, addr_hit_n, busy_n;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
`ifdef I2C_GLITCH_FILTER_EN
  // Window = last two sync stages plus one history flop: three consecutive samples must agree.
  logic scl_h, sda_h, scl_f, sda_f;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      scl_h <= 1'b1;
      sda_h <= 1'b1;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= scl_sync[SYNC_STAGES-1];
      sda_h <= sda_sync[SYNC_STAGES-1];
      if (scl_sync[SYNC_STAGES-1] == scl_sync[SYNC_STAGES-2] && scl_sync[SYNC_STAGES-1] == scl_h) scl_f <= scl_h;
      if (sda_sync[SYNC_STAGES-1] == sda_sync[SYNC_STAGES-2] && sda_sync[SYNC_STAGES-1] == sda_h) sda_f <= sda_h;
    end
  assign scl_s = scl_f;
  assign sda_s = sda_f;
`else
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start = scl_s & scl_d & sda_d & ~sda_s;
  assign stop = scl_s & scl_d & ~sda_d & sda_s;
  assign match = shift[7:1] == TARGET_ADDR && !shift[0];
  assign cnt_inc = cnt == 4'd8 ? cnt : cnt + 4'd1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      sda_oe <= 1'b0;
      addr_hit <= 1'b0;
      busy <= 1'b0;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
      state <= state_n;
      cnt <= cnt_n;
      shift <= shift_n;
      rx_data <= rx_data_n;
      rx_valid <= rx_valid_n;
      sda_oe <= sda_oe_n;
      addr_hit <= addr_hit_n;
      busy <= busy_n;
    end
  // START outranks STOP and SCL edges; the shift register is never cleared, only the count qualifies a byte.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shift_n = shift;
    rx_data_n = rx_data;
    rx_valid_n = 1'b0;
    sda_oe_n = sda_oe;
    addr_hit_n = addr_hit;
    busy_n = busy;
    if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      sda_oe_n = 1'b0;
      addr_hit_n = 1'b0;
      busy_n = 1'b1;
    end else if (stop) begin
      state_n = IDLE;
      sda_oe_n = 1'b0;
      addr_hit_n = 1'b0;
      busy_n = 1'b0;
    end else
      case (state)
        ADDR:
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n = cnt_inc;
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = match ? ADDR_ACK : IGNORE;
            sda_oe_n = match;
            addr_hit_n = match;
          end
        DATA:
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n = cnt_inc;
            if (cnt == 4'd7) begin
              rx_data_n = {shift[6:0], sda_s};
              rx_valid_n = 1'b1;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = DATA_ACK;
            sda_oe_n = 1'b1;
          end
        ADDR_ACK, DATA_ACK:
          if (scl_fall) begin
            state_n = DATA;
            sda_oe_n = 1'b0;
            cnt_n = '0;
          end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_i2c_target_rx_ctrl.sv
// tb_i2c_target_rx_ctrl: bus-master driver plus scoreboard for the I2C target receiver.
module tb_i2c_target_rx_ctrl;
  localparam int Q = 6;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_line;
  logic sda_oe, rx_valid, addr_hit, busy;
  logic [7:0] rx_data;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] last_rx = 8'h00;
  bit oe_allowed = 1'b0;
  int checks = 0;
  int errors = 0;
  assign sda_line = sda_m & ~sda_oe;
  always #5 clock = ~clock;
  i2c_target_rx_ctrl dut (
    .clock(clock),
    .reset_n(reset_n),
    .scl_in(scl),
    .sda_in(sda_line),
    .sda_oe(sda_oe),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .addr_hit(addr_hit),
    .busy(busy)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clock)
    if (reset_n) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) check("unexpected_rx_valid", 32'd1, 32'd0);
        else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (sda_oe) check("sda_oe_window", {31'd0, oe_allowed}, 32'd1);
    end
  task automatic wc(input int n);
    repeat (n) @(posedge clock);
  endtask
  task automatic bit_tx(input logic b, input bit g);
    wc(Q);
    sda_m = b;
    wc(Q);
    scl = 1'b1;
    wc(Q);
    if (g) begin
      scl = 1'b0;
      wc(2);
      scl = 1'b1;
    end
    wc(Q);
    scl = 1'b0;
  endtask
  task automatic byte_tx(input logic [7:0] d, input int g);
    for (int i = 7; i >= 0; i--) bit_tx(d[i], i == g);
  endtask
  task automatic ack_rx(input logic exp, input string name);
    oe_allowed = !exp;
    wc(Q);
    sda_m = 1'b1;
    wc(Q);
    scl = 1'b1;
    wc(Q);
    @(negedge clock);
    check(name, {31'd0, sda_line}, {31'd0, exp});
    wc(Q);
    scl = 1'b0;
    wc(Q);
    oe_allowed = 1'b0;
  endtask
  task automatic start_c();
    wc(Q);
    sda_m = 1'b1;
    wc(Q);
    scl = 1'b1;
    wc(Q);
    sda_m = 1'b0;
    wc(Q);
    scl = 1'b0;
  endtask
  task automatic stop_c();
    wc(Q);
    sda_m = 1'b0;
    wc(Q);
    scl = 1'b1;
    wc(Q);
    sda_m = 1'b1;
    wc(2 * Q);
  endtask
  // Reference: a write to 0x42 ACKs the address and every full data byte and delivers each one;
  // anything else is NACKed and delivers nothing; partial bytes (<=6 bits) never deliver.
  task automatic xfer(input logic [7:0] addr, input int partial, input bit stop_end, input int g);
    bit hit;
    hit = addr[7:1] == 7'h42 && !addr[0];
    start_c();
    @(negedge clock);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    byte_tx(addr, -1);
    ack_rx(!hit, "addr_ack");
    check("addr_hit", {31'd0, addr_hit}, {31'd0, hit});
    for (int i = 0; i < tx_q.size(); i++) begin
      if (hit) begin
        exp_q.push_back(tx_q[i]);
        last_rx = tx_q[i];
      end
      byte_tx(tx_q[i], i == 0 ? g : -1);
      ack_rx(!hit, "data_ack");
    end
    for (int i = 0; i < partial; i++) bit_tx(1'($urandom_range(0, 1)), 1'b0);
    if (stop_end) begin
      stop_c();
      @(negedge clock);
      check("busy_after_stop", {31'd0, busy}, 32'd0);
      check("addr_hit_after_stop", {31'd0, addr_hit}, 32'd0);
      check("rx_data_hold", {24'd0, rx_data}, {24'd0, last_rx});
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (20) begin
      @(posedge clock);
      scl = 1'($urandom);
      sda_m = 1'($urandom);
      @(negedge clock);
      check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    end
    scl = 1'b1;
    sda_m = 1'b1;
    wc(5);
    @(negedge clock);
    reset_n = 1'b1;
    wc(20);
    @(negedge clock);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_addr_hit", {31'd0, addr_hit}, 32'd0);
    tx_q = {8'hA5};
    xfer(8'h84, 0, 1'b1, -1);
    tx_q = {8'h5A};
    xfer(8'h86, 0, 1'b1, -1);
    tx_q = {8'h77};
    xfer(8'h85, 0, 1'b1, -1);
    tx_q = {8'h11, 8'hFE};
    xfer(8'h84, 0, 1'b1, -1);
    tx_q.delete();
    xfer(8'h84, 5, 1'b1, -1);
    tx_q = {8'h3C};
    xfer(8'h84, 0, 1'b1, -1);
    tx_q = {8'h99};
    xfer(8'h84, 3, 1'b0, -1);
    tx_q = {8'h3C};
    xfer(8'h84, 0, 1'b1, -1);
    repeat (10) begin
      logic [7:0] a;
      int sel;
      sel = $urandom_range(0, 3);
      a = sel < 2 ? 8'h84 : (sel == 2 ? 8'h85 : 8'($urandom));
      tx_q.delete();
      repeat ($urandom_range(0, 3)) tx_q.push_back(8'($urandom));
      xfer(a, $urandom_range(0, 1) ? $urandom_range(1, 6) : 0, 1'($urandom), -1);
    end
    tx_q.delete();
    xfer(8'h84, 0, 1'b1, -1);
`ifdef I2C_GLITCH_FILTER_EN
    tx_q = {8'hB6, 8'h4D};
    xfer(8'h84, 0, 1'b1, 4);
`endif
    start_c();
    byte_tx(8'h84, -1);
    ack_rx(1'b0, "addr_ack_pre_reset");
    exp_q.push_back(8'hE7);
    byte_tx(8'hE7, -1);
    oe_allowed = 1'b1;
    wc(Q);
    @(negedge clock);
    check("oe_in_data_ack", {31'd0, sda_oe}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("oe_async_drop", {31'd0, sda_oe}, 32'd0);
    oe_allowed = 1'b0;
    sda_m = 1'b1;
    scl = 1'b1;
    last_rx = 8'h00;
    wc(5);
    @(negedge clock);
    check("rx_data_after_reset", {24'd0, rx_data}, 32'd0);
    reset_n = 1'b1;
    wc(10);
    tx_q = {8'hC3};
    xfer(8'h84, 0, 1'b1, -1);
    wc(50);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
